// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction fields, flag indices, FSM states.
// Build option ALU_SEQ_ILLEGAL_TRAP_EN selects trap-on-undefined-opcode behaviour in the top.
package alu_seq_pkg;

   localparam logic [5:0] OpAdd = 6'b000110;
   localparam logic [5:0] OpSub = 6'b001001;
   localparam logic [5:0] OpAnd = 6'b001011;
   localparam logic [5:0] OpOr  = 6'b001010;
   localparam logic [5:0] OpNot = 6'b001100;
   localparam logic [5:0] OpXor = 6'b001110;
   localparam logic [5:0] OpMov = 6'b011100;
   localparam logic [5:0] OpCmp = 6'b011101;
   localparam logic [5:0] OpBeq = 6'b100100;

   localparam int unsigned OpcodeMsb = 31;
   localparam int unsigned OpcodeLsb = 26;
   localparam int unsigned SBit      = 25;
   localparam int unsigned RdMsb     = 24;
   localparam int unsigned RdLsb     = 21;
   localparam int unsigned RnMsb     = 20;
   localparam int unsigned RnLsb     = 17;
   localparam int unsigned RmMsb     = 16;
   localparam int unsigned RmLsb     = 13;
   localparam int unsigned ImmMsb    = 12;
   localparam int unsigned ImmLsb    = 0;
   localparam int unsigned TargetMsb = 23;
   localparam int unsigned TargetLsb = 0;

   // Flag register layout is {N,Z,C,V}
   localparam int unsigned FlagN = 3;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StExec,
      StWb,
      StHalt
   } state_e;

   // target overlaps rd/rn/rm/imm13; only BEQ interprets it
   typedef struct packed {
      logic [5:0]  opcode;
      logic        s;
      logic [3:0]  rd;
      logic [3:0]  rn;
      logic [3:0]  rm;
      logic [12:0] imm13;
      logic [23:0] target;
   } instr_t;

   function automatic instr_t decode(input logic [31:0] w);
      instr_t d;
      d.opcode = w[OpcodeMsb:OpcodeLsb];
      d.s      = w[SBit];
      d.rd     = w[RdMsb:RdLsb];
      d.rn     = w[RnMsb:RnLsb];
      d.rm     = w[RmMsb:RmLsb];
      d.imm13  = w[ImmMsb:ImmLsb];
      d.target = w[TargetMsb:TargetLsb];
      return d;
   endfunction

   function automatic logic is_defined(input logic [5:0] op);
      case (op)
         OpAdd, OpSub, OpAnd, OpOr, OpNot, OpXor, OpMov, OpCmp, OpBeq: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic writes_reg(input logic [5:0] op);
      case (op)
         OpAdd, OpSub, OpAnd, OpOr, OpNot, OpXor, OpMov: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic may_set_flags(input logic [5:0] op);
      case (op)
         OpAdd, OpSub, OpCmp: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 16x32 register file: two operand read ports, one debug read port, one write port.
// Contents clear asynchronously on rst; reads are combinational.
module alu_seq_regfile
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  ra_addr_i,
   output logic [31:0] ra_data_o,
   input  logic [3:0]  rb_addr_i,
   output logic [31:0] rb_data_o,
   input  logic [3:0]  dbg_addr_i,
   output logic [31:0] dbg_data_o,
   input  logic        we_i,
   input  logic [3:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] regs_q [16];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign ra_data_o  = regs_q[ra_addr_i];
   assign rb_data_o  = regs_q[rb_addr_i];
   assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer driving an external ALU (IDLE->DECODE->EXEC->WB).
// Define ALU_SEQ_ILLEGAL_TRAP_EN to trap undefined opcodes into a sticky HALT; otherwise they are NOPs.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic [5:0]  alu_opcode,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_s,
   output logic [23:0] alu_pc_br,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_cpsr,
   output logic [23:0] pc,
   output logic [3:0]  flags,
   output logic        busy,
   output logic        illegal,
   input  logic [3:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   state_e      state_q, state_d;
   logic [31:0] instr_q;
   logic [31:0] res_q;
   logic [3:0]  cpsr_q;
   logic [23:0] pc_q, pc_d;
   logic [3:0]  flags_q, flags_d;
   instr_t      dec;
   logic        accept;
   logic        rf_we;
   logic [31:0] rn_data, rm_data;

   assign dec    = decode(instr_q);
   assign accept = instr_valid && instr_ready;

   alu_seq_regfile u_regfile (
      .clk        (clk),
      .rst        (rst),
      .ra_addr_i  (dec.rn),
      .ra_data_o  (rn_data),
      .rb_addr_i  (dec.rm),
      .rb_data_o  (rm_data),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .we_i       (rf_we),
      .wa_i       (dec.rd),
      .wd_i       (res_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (instr_valid) state_d = StDecode;
         end
         StDecode: begin
            state_d = StExec;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            if (!is_defined(dec.opcode)) state_d = StHalt;
`endif
         end
         StExec:  state_d = StWb;
         StWb:    state_d = StIdle;
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   assign instr_ready = (state_q == StIdle);
   assign busy        = (state_q != StIdle);

   // ALU operands are only driven during EXEC; zero otherwise
   always_comb begin
      alu_opcode = '0;
      alu_a      = '0;
      alu_b      = '0;
      alu_s      = 1'b0;
      alu_pc_br  = '0;
      if (state_q == StExec) begin
         alu_opcode = dec.opcode;
         alu_a      = rn_data;
         alu_b      = (dec.opcode == OpMov) ? {19'b0, dec.imm13} : rm_data;
         alu_s      = dec.s;
         if (dec.opcode == OpBeq) alu_pc_br = dec.target;
      end
   end

   // Flags only change in WB, so flags_q in WB still holds the value seen during EXEC
   always_comb begin
      pc_d    = pc_q;
      flags_d = flags_q;
      rf_we   = 1'b0;
      if (state_q == StWb) begin
         rf_we = writes_reg(dec.opcode);
         if (may_set_flags(dec.opcode) && dec.s) flags_d = cpsr_q;
         if ((dec.opcode == OpBeq) && flags_q[FlagZ]) begin
            pc_d = dec.target;
         end else begin
            pc_d = pc_q + 24'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         res_q   <= '0;
         cpsr_q  <= '0;
         pc_q    <= '0;
         flags_q <= '0;
      end else begin
         if (accept) instr_q <= instr;
         if (state_q == StExec) begin
            res_q  <= alu_result;
            cpsr_q <= alu_cpsr;
         end
         pc_q    <= pc_d;
         flags_q <= flags_d;
      end
   end

   assign pc    = pc_q;
   assign flags = flags_q;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else if ((state_q == StDecode) && !is_defined(dec.opcode)) begin
         illegal_q <= 1'b1;
      end
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

endmodule
